// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         add_n;
  logic         sat;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         c_out;
  logic         overflow;

  modport master (
    output start, x, y, add_n, sat,
    input  busy, done, s, c_out, overflow
  );

  modport slave (
    input  start, x, y, add_n, sat,
    output busy, done, s, c_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial signed add/subtract: D bits per clock through a registered-carry slice,
// with carry-out, signed overflow and optional saturation reported on a one-cycle done pulse.
//
// state | meaning
// IDLE  | busy=0, waiting for start; operands latched on accept
// RUN   | busy=1, one D-bit digit resolved per clock, K digits total
module serial_addsub #(
  parameter int N = 8,
  parameter int D = 2
) (
  input logic           clk,
  input logic           reset_n,
  serial_addsub_if.slave bus
);
  localparam int K  = N / D;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  generate
    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
      $error("serial_addsub: N must be >= 2 and a multiple of D, with 1 <= D <= N");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   xr;
  logic [N-1:0]   yr;
  logic [N-1:0]   rr;
  logic           carry;
  logic           satr;
  logic           xm;
  logic           ym;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   s_r;
  logic           c_r;
  logic           ov_r;
  logic           done_r;
  logic           busy_c;

  logic [D:0]     dsum;
  logic [N-1:0]   r_full;
  logic           ov_raw;
  logic [N-1:0]   s_fin;

  assign dsum = {1'b0, xr[D-1:0]} + {1'b0, yr[D-1:0]} + {{D{1'b0}}, carry};

  // The new digit enters at the top; after K shifts the first digit sits at bit 0.
  generate
    if (D < N) begin : g_shift
      assign r_full = {dsum[D-1:0], rr[N-1:D]};
    end else begin : g_whole
      assign r_full = dsum[D-1:0];
    end
  endgenerate

  assign ov_raw = (xm & ym & ~r_full[N-1]) | (~xm & ~ym & r_full[N-1]);
  assign s_fin  = (satr & ov_raw) ? (xm ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                                  : r_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == RUN);
  end

  // Operand MSBs are taken at accept, which is the same information digit 0 would see.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xr     <= '0;
      yr     <= '0;
      rr     <= '0;
      carry  <= 1'b0;
      satr   <= 1'b0;
      xm     <= 1'b0;
      ym     <= 1'b0;
      cnt    <= '0;
      s_r    <= '0;
      c_r    <= 1'b0;
      ov_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            xr    <= bus.x;
            yr    <= bus.y ^ {N{bus.add_n}};
            rr    <= '0;
            carry <= bus.add_n;
            satr  <= bus.sat;
            xm    <= bus.x[N-1];
            ym    <= bus.y[N-1] ^ bus.add_n;
            cnt   <= '0;
          end
        end
        RUN: begin
          xr    <= xr >> D;
          yr    <= yr >> D;
          rr    <= r_full;
          carry <= dsum[D];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            s_r    <= s_fin;
            c_r    <= dsum[D];
            ov_r   <= ov_raw;
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_r;
  assign bus.s        = s_r;
  assign bus.c_out    = c_r;
  assign bus.overflow = ov_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed checks of the N=8/D=2 adder/subtractor plus a randomized sweep of other widths.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.N(8))  m_if ();
  serial_addsub_if #(.N(8))  a_if ();
  serial_addsub_if #(.N(8))  b_if ();
  serial_addsub_if #(.N(16)) c_if ();

  serial_addsub #(.N(8),  .D(2)) dut   (.clk(clk), .reset_n(reset_n), .bus(m_if.slave));
  serial_addsub #(.N(8),  .D(1)) dut81 (.clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  serial_addsub #(.N(8),  .D(8)) dut88 (.clk(clk), .reset_n(reset_n), .bus(b_if.slave));
  serial_addsub #(.N(16), .D(4)) dut164(.clk(clk), .reset_n(reset_n), .bus(c_if.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on the main instance and watches 12 cycles for done pulses.
  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic sub,
                        input logic st, output int lat, output int ndone);
    m_if.x = xv; m_if.y = yv; m_if.add_n = sub; m_if.sat = st; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    lat = 0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (m_if.done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  // Reference built on exact signed arithmetic; returns {overflow, c_out, s}.
  function automatic logic [17:0] ref_op(input int n, input logic [15:0] a, input logic [15:0] b,
                                         input logic sub, input logic st);
    longint mask, ua, ub, sa, sb, ex, mx, mn, raw;
    logic ov, c;
    logic [15:0] r;
    mask = (longint'(1) << n) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[n-1] ? ua - (longint'(1) << n) : ua;
    sb = b[n-1] ? ub - (longint'(1) << n) : ub;
    ex = sub ? sa - sb : sa + sb;
    mx = (longint'(1) << (n - 1)) - 1;
    mn = -(longint'(1) << (n - 1));
    ov = (ex > mx) || (ex < mn);
    raw = sub ? ua + ((~ub) & mask) + 1 : ua + ub;
    c = ((raw >> n) & 1) != 0;
    r = 16'(ex & mask);
    if (st && ov) r = (ex > mx) ? 16'(mx) : 16'(mn & mask);
    return {ov, c, r};
  endfunction

  task automatic test_reset();
    m_if.start = 0; m_if.x = 0; m_if.y = 0; m_if.add_n = 0; m_if.sat = 0;
    a_if.start = 0; a_if.x = 0; a_if.y = 0; a_if.add_n = 0; a_if.sat = 0;
    b_if.start = 0; b_if.x = 0; b_if.y = 0; b_if.add_n = 0; b_if.sat = 0;
    c_if.start = 0; c_if.x = 0; c_if.y = 0; c_if.add_n = 0; c_if.sat = 0;
    reset_n = 1'b0;
    #23;
    reset_n = 1'b1;
    tick();
    tick();
    total++; if (m_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", m_if.busy); end
    total++; if (m_if.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", m_if.done); end
    total++; if (m_if.s !== 8'h00) begin bad++; $display("FAIL reset_s got=%h want=00", m_if.s); end
    total++; if (m_if.c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out got=%b want=0", m_if.c_out); end
    total++; if (m_if.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", m_if.overflow); end
  endtask

  task automatic test_add();
    int lat, nd;
    run_op(8'd100, 8'd27, 1'b0, 1'b0, lat, nd);
    total++; if (lat != 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
    total++; if (nd != 1) begin bad++; $display("FAIL add_done_count got=%0d want=1", nd); end
    total++; if (m_if.s !== 8'h7F) begin bad++; $display("FAIL add_s got=%h want=7f", m_if.s); end
    total++; if (m_if.c_out !== 1'b0) begin bad++; $display("FAIL add_c_out got=%b want=0", m_if.c_out); end
    total++; if (m_if.overflow !== 1'b0) begin bad++; $display("FAIL add_ovf got=%b want=0", m_if.overflow); end
  endtask

  task automatic test_overflow_sat();
    int lat, nd;
    run_op(8'd100, 8'd28, 1'b0, 1'b0, lat, nd);
    total++; if (m_if.s !== 8'h80) begin bad++; $display("FAIL ovf_s got=%h want=80", m_if.s); end
    total++; if (m_if.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", m_if.overflow); end
    total++; if (m_if.c_out !== 1'b0) begin bad++; $display("FAIL ovf_c_out got=%b want=0", m_if.c_out); end
    run_op(8'd100, 8'd28, 1'b0, 1'b1, lat, nd);
    total++; if (m_if.s !== 8'h7F) begin bad++; $display("FAIL sat_s got=%h want=7f", m_if.s); end
    total++; if (m_if.overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", m_if.overflow); end
  endtask

  task automatic test_subtract();
    int lat, nd;
    run_op(8'd5, 8'd7, 1'b1, 1'b0, lat, nd);
    total++; if (m_if.s !== 8'hFE) begin bad++; $display("FAIL sub1_s got=%h want=fe", m_if.s); end
    total++; if (m_if.c_out !== 1'b0) begin bad++; $display("FAIL sub1_c_out got=%b want=0", m_if.c_out); end
    total++; if (m_if.overflow !== 1'b0) begin bad++; $display("FAIL sub1_ovf got=%b want=0", m_if.overflow); end
    run_op(8'd7, 8'd5, 1'b1, 1'b0, lat, nd);
    total++; if (m_if.s !== 8'h02) begin bad++; $display("FAIL sub2_s got=%h want=02", m_if.s); end
    total++; if (m_if.c_out !== 1'b1) begin bad++; $display("FAIL sub2_c_out got=%b want=1", m_if.c_out); end
    run_op(8'h80, 8'd1, 1'b1, 1'b1, lat, nd);
    total++; if (m_if.s !== 8'h80) begin bad++; $display("FAIL sub3_s got=%h want=80", m_if.s); end
    total++; if (m_if.overflow !== 1'b1) begin bad++; $display("FAIL sub3_ovf got=%b want=1", m_if.overflow); end
    total++; if (m_if.c_out !== 1'b1) begin bad++; $display("FAIL sub3_c_out got=%b want=1", m_if.c_out); end
  endtask

  task automatic test_back_to_back();
    int lat, nd;
    m_if.x = 8'd100; m_if.y = 8'd27; m_if.add_n = 1'b0; m_if.sat = 1'b0; m_if.start = 1'b1;
    tick();                                   // T0
    m_if.start = 1'b0;
    tick();                                   // T1
    m_if.start = 1'b1; m_if.x = 8'd1; m_if.y = 8'd1;
    tick();                                   // T2, must be ignored
    m_if.start = 1'b0;
    total++; if (m_if.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_t2 got=%b want=1", m_if.busy); end
    tick();                                   // T3
    total++; if (m_if.done !== 1'b0) begin bad++; $display("FAIL b2b_done_t3 got=%b want=0", m_if.done); end
    total++; if (m_if.s !== 8'h80) begin bad++; $display("FAIL b2b_s_stable got=%h want=80", m_if.s); end
    tick();                                   // T4
    total++; if (m_if.done !== 1'b1) begin bad++; $display("FAIL b2b_done_t4 got=%b want=1", m_if.done); end
    total++; if (m_if.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_t4 got=%b want=0", m_if.busy); end
    total++; if (m_if.s !== 8'h7F) begin bad++; $display("FAIL b2b_s1 got=%h want=7f", m_if.s); end
    m_if.x = 8'd7; m_if.y = 8'd5; m_if.add_n = 1'b1; m_if.start = 1'b1;
    tick();                                   // T5, accepted
    total++; if (m_if.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_t5 got=%b want=1", m_if.busy); end
    total++; if (m_if.done !== 1'b0) begin bad++; $display("FAIL b2b_done_t5 got=%b want=0", m_if.done); end
    m_if.start = 1'b0; m_if.x = 8'h55; m_if.y = 8'h33; m_if.add_n = 1'b0; m_if.sat = 1'b1;
    lat = 0;
    nd = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (m_if.done) begin
        nd++;
        if (lat == 0) lat = i;
      end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL b2b_latency2 got=%0d want=4", lat); end
    total++; if (nd != 1) begin bad++; $display("FAIL b2b_done_count2 got=%0d want=1", nd); end
    total++; if (m_if.s !== 8'h02) begin bad++; $display("FAIL b2b_s2 got=%h want=02", m_if.s); end
    total++; if (m_if.c_out !== 1'b1) begin bad++; $display("FAIL b2b_c_out2 got=%b want=1", m_if.c_out); end
  endtask

  task automatic test_reset_mid();
    int nd;
    m_if.x = 8'd100; m_if.y = 8'd28; m_if.add_n = 1'b0; m_if.sat = 1'b0; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    total++; if (m_if.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", m_if.busy); end
    total++; if (m_if.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", m_if.done); end
    total++; if (m_if.s !== 8'h00) begin bad++; $display("FAIL rstmid_s got=%h want=00", m_if.s); end
    total++; if (m_if.c_out !== 1'b0) begin bad++; $display("FAIL rstmid_c_out got=%b want=0", m_if.c_out); end
    total++; if (m_if.overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b want=0", m_if.overflow); end
    #10;
    reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_if.done) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", nd); end
  endtask

  task automatic test_sweep();
    logic [17:0] e;
    logic [9:0]  e8;
    logic [15:0] xa, ya, xb, yb, xc, yc;
    logic        sba, sta, sbb, stb, sbc, stc;
    int          da, db, dc;
    for (int op = 0; op < 1000; op++) begin
      xa = 16'($urandom_range(255)); ya = 16'($urandom_range(255));
      xb = 16'($urandom_range(255)); yb = 16'($urandom_range(255));
      xc = 16'($urandom);            yc = 16'($urandom);
      sba = 1'($urandom); sta = 1'($urandom);
      sbb = 1'($urandom); stb = 1'($urandom);
      sbc = 1'($urandom); stc = 1'($urandom);
      a_if.x = xa[7:0]; a_if.y = ya[7:0]; a_if.add_n = sba; a_if.sat = sta; a_if.start = 1'b1;
      b_if.x = xb[7:0]; b_if.y = yb[7:0]; b_if.add_n = sbb; b_if.sat = stb; b_if.start = 1'b1;
      c_if.x = xc;      c_if.y = yc;      c_if.add_n = sbc; c_if.sat = stc; c_if.start = 1'b1;
      tick();
      a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
      a_if.x = ~a_if.x; b_if.y = ~b_if.y; c_if.x = ~c_if.x;
      da = 0; db = 0; dc = 0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (a_if.done) begin
          da++;
          e = ref_op(8, xa, ya, sba, sta);
          e8 = {e[17:16], e[7:0]};
          total++;
          if ({a_if.overflow, a_if.c_out, a_if.s} !== e8) begin
            bad++; $display("FAIL sweep_8_1 op=%0d got=%h want=%h", op, {a_if.overflow, a_if.c_out, a_if.s}, e8);
          end
        end
        if (b_if.done) begin
          db++;
          e = ref_op(8, xb, yb, sbb, stb);
          e8 = {e[17:16], e[7:0]};
          total++;
          if ({b_if.overflow, b_if.c_out, b_if.s} !== e8) begin
            bad++; $display("FAIL sweep_8_8 op=%0d got=%h want=%h", op, {b_if.overflow, b_if.c_out, b_if.s}, e8);
          end
        end
        if (c_if.done) begin
          dc++;
          e = ref_op(16, xc, yc, sbc, stc);
          total++;
          if ({c_if.overflow, c_if.c_out, c_if.s} !== e) begin
            bad++; $display("FAIL sweep_16_4 op=%0d got=%h want=%h", op, {c_if.overflow, c_if.c_out, c_if.s}, e);
          end
        end
      end
      total++;
      if (da != 1 || db != 1 || dc != 1) begin
        bad++; $display("FAIL sweep_done_count op=%0d got=%0d/%0d/%0d want=1/1/1", op, da, db, dc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow_sat();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Multi-cycle, digit-serial signed adder/subtractor for the arithmetic datapath. It latches two N-bit two's-complement operands on a start pulse and resolves the result D bits per clock through a D-bit ripple slice with a registered carry. It reports carry-out, signed overflow and an optional saturated result, with a start/busy/done handshake. Narrow D trades latency for area relative to a full-width ripple-carry add/subtract.

## Interface
- N, 8: operand and result width in bits; N ≥ 2.
- D, 2: digit width processed per cycle; 1 ≤ D ≤ N, N % D == 0 (elaboration error otherwise). K = N/D digit cycles.
- clk  input  1  rising-edge clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- x  input  N  minuend/augend, signed; latched on accepted start.
- y  input  N  subtrahend/addend, signed; latched on accepted start.
- add_n  input  1  0 = x+y, 1 = x−y; latched on accepted start.
- sat  input  1  1 = clamp s to signed min/max on overflow; latched on accepted start.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse, result valid.
- s  output  N  result; held until the next completion.
- c_out  output  1  raw carry out of bit N−1; unaffected by sat.
- overflow  output  1  signed overflow of the unsaturated result.

## Operation
- FSM states:
  - IDLE (busy=0): accepts start.
  - RUN (busy=1): processes K digits.
- IDLE with start=1:
  - Latch xr ← x and yr ← y ^ {N{add_n}}.
  - Set carry ← add_n, satr ← sat, digit counter ← 0.
  - Go to RUN.
- RUN, each cycle:
  - Compute {c, sum} = xr[D−1:0] + yr[D−1:0] + carry.
  - Shift sum into the top of the result shift register; shift xr and yr right by D.
  - Set carry ← c and increment the counter.
  - Capture the MSBs of x and of y^add_n at digit 0 so overflow can be evaluated at the end.
- After digit K−1:
  - Raw result r is complete.
  - overflow = (xm & ym & ~r[N−1]) | (~xm & ~ym & r[N−1]), where xm and ym are the captured MSBs.
  - c_out = final carry.
  - s = r, unless satr & overflow: then s = 0x7F…F when xm=0, and 0x80…0 when xm=1.
  - Register s, c_out and overflow, pulse done, return to IDLE.
- start while busy=1 is ignored; no queueing.
- Operands may change after acceptance without affecting the operation in flight.
- Reset values: busy=0, done=0, s=0, c_out=0, overflow=0, state=IDLE, internal registers 0.
- Reset asserted mid-operation aborts it. No done pulse is issued, and outputs return to reset values.

## Timing
- Start accepted at rising edge T0 (start=1, busy=0); busy=1 after T0.
- Digits are resolved on edges T1…TK.
- After edge TK:
  - s, c_out and overflow take their new values.
  - done=1 for exactly one cycle and busy=0.
- Latency is K cycles from the accepting edge to done. Edge TK itself does not accept start; the next start is accepted at edge TK+1, giving a maximum issue rate of one op per K+1 cycles.
- D = N gives K = 1: single-cycle registered operation, same handshake.
- s, c_out and overflow change only on the done edge or on reset; they are stable while busy.
- Critical path is one D-bit ripple plus the carry register; there is no N-wide combinational path except the saturation mux.

## Test plan
N=8, D=2 (K=4) unless stated.
- Reset, then idle: busy=0, done=0, s=0x00, c_out=0, overflow=0.
- Basic add: x=100, y=27, add_n=0, sat=0, start at T0 → done exactly after T4, s=0x7F, c_out=0, overflow=0.
- Overflow and saturation, x=100, y=28:
  - sat=0 → s=0x80, overflow=1, c_out=0.
  - sat=1 → s=0x7F, overflow=1.
- Subtract:
  - x=5, y=7, add_n=1 → s=0xFE, c_out=0, overflow=0.
  - x=7, y=5 → s=0x02, c_out=1.
  - x=0x80, y=1, sat=1 → s=0x80, overflow=1, c_out=1.
- Handshake:
  - Pulse start again at T2 with different operands → ignored; first result only, one done pulse.
  - Start at T5 → accepted, second done after T9.
  - Change x/y during busy → result unaffected.
- Reset and parameters:
  - reset_n low at T2 → busy, done and outputs go to 0 asynchronously; no done pulse follows.
  - Repeat a random 1000-op sweep for (N,D) = (8,1), (8,8), (16,4) against a reference model of s, c_out and overflow.
